gru_seq_feeder: RTL and testbench
=================================

// Module: gru_seq_feeder
// PURPOSE
//  Input-side sequencer for the GRU datapath. Accepts one input sequence as a
//  serial feature stream with valid/ready handshake and buffers it. It then
//  presents x_t one step vector at a time. Each vector is held stable for
//  STEP_CYCLES clocks, which matches the GRU cell step period.
//  Sits between the sample source and gru_basic's x_t input.
// PARAMETERS
//  x_SIZE          6   features per time step
//  SEQUENCE_LENGTH 15  time steps per sequence
//  WIDTH           16  feature word width, signed fixed point (passed through)
//  STEP_CYCLES     19  clocks each x_t vector is held; gru_delay_counter period
// PORTS
//  clk      in   1            rising-edge clock
//  reset    in   1            asynchronous, active-high reset
//  flush    in   1            sync clear of buffers, counters and FSM
//  s_data   in   WIDTH        input feature word, signed
//  s_valid  in   1            s_data valid
//  s_ready  out  1            feeder can accept s_data
//  x_t      out  WIDTH*x_SIZE unpacked [0:x_SIZE-1] step vector to the GRU
//  x_valid  out  1            x_t holds a real step
//  x_first  out  1            high for the whole step-0 window
//  x_last   out  1            high for the whole step-(SEQUENCE_LENGTH-1) window
//  seq_done out  1            one-cycle pulse after the last window ends
// BEHAVIOUR
//  - Reset values: x_t all 0; x_valid, x_first, x_last, seq_done = 0.
//    s_ready = 0 while reset is high and 1 in the first cycle after release.
//    Reset clears immediately, including mid-stream; the buffer becomes empty.
//  - Beat k is accepted when s_valid && s_ready. It is written to
//    step k/x_SIZE, feature k%x_SIZE. A sequence is x_SIZE*SEQUENCE_LENGTH
//    beats (90 by default).
//  - FSM per bank: LOAD -> FULL -> STREAM -> LOAD.
//    LOAD:   accepts beats. Accepting the final beat moves the bank to FULL.
//    FULL:   waits until the output is free.
//    STREAM: steps through the windows. The bank returns to LOAD after
//            the last window.
//  - Latency: the final beat is accepted on edge T. If the output is idle,
//    x_valid and x_first are high with x_t = step 0 from edge T+1.
//  - Pacing: a pace counter runs 0..STEP_CYCLES-1. On wrap, the step counter
//    advances and x_t updates on the same edge. x_t never changes inside a
//    window.
//  - Last window: when it ends, x_valid, x_first and x_last drop and x_t
//    returns to 0 on that edge. seq_done pulses for exactly 1 cycle on the
//    same edge.
//  - s_ready is low when no bank is in LOAD.
//  - flush clears all banks, counters and outputs, as reset does, on the next
//    edge. If flush and a beat handshake occur in the same cycle, flush wins
//    and the beat is dropped. The next accepted beat is index 0.
//  - No arithmetic is performed on data. Words pass through bit-exact.
//    Counter widths are $clog2 of the respective range.
// CONFIGURATION
//  GRU_FEEDER_PINGPONG_EN
//   Defined: two banks. The next sequence loads while the other bank
//     streams, so s_ready stays high during STREAM.
//     If the other bank is FULL when a stream ends, its step 0 appears on the
//     edge right after the last window. In that case x_valid does not drop,
//     seq_done still pulses and x_first rises.
//   Undefined: one bank. s_ready is low from the final beat until the
//     seq_done edge. In the cycle after seq_done, s_ready is high again.
// TESTING (x_SIZE=6, SEQUENCE_LENGTH=15, STEP_CYCLES=19)
//  1. Assert reset with stimulus active -> all outputs 0 and s_ready=0; after
//     release, s_ready=1.
//  2. Send 90 beats with s_data=k and no gaps -> x_t={0..5} for 19 cycles with
//     x_first=1, then {6..11}, and so on. The final window is {84..89} with
//     x_last=1. x_valid is high for 285 cycles, then seq_done pulses once.
//  3. Same 90 beats with random s_valid gaps -> output is identical to test 2
//     and only starts later.
//  4. PINGPONG defined: load sequence B (s_data=100+k) during A's stream ->
//     B step {100..105} starts on the edge after A's last window and x_valid
//     never drops. Undefined: the 91st beat stalls on s_ready=0 until
//     seq_done.
//  5. Assert async reset in the middle of window 7 -> outputs are 0 before
//     the next edge. A new 90-beat load after release streams from step 0.
//  6. Assert flush together with the handshake of beat 40 -> beat 40 is
//     dropped. The next beat, s_data=0x7FFF, appears at x_t[0] of step 0.

Source files
------------

// File: rtl/gru_seq_feeder.sv
// Buffers one serial feature sequence and replays it as x_t step vectors.
// Define GRU_FEEDER_PINGPONG_EN for two banks (load next while streaming).
module gru_seq_feeder #(
    parameter int x_SIZE          = 6,
    parameter int SEQUENCE_LENGTH = 15,
    parameter int WIDTH           = 16,
    parameter int STEP_CYCLES     = 19
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    flush,
    input  logic signed [WIDTH-1:0] s_data,
    input  logic                    s_valid,
    output logic                    s_ready,
    output logic signed [WIDTH-1:0] x_t [0:x_SIZE-1],
    output logic                    x_valid,
    output logic                    x_first,
    output logic                    x_last,
    output logic                    seq_done
);

`ifdef GRU_FEEDER_PINGPONG_EN
    localparam int NB = 2;
    localparam bit PP = 1'b1;
`else
    localparam int NB = 1;
    localparam bit PP = 1'b0;
`endif
    localparam int N  = x_SIZE * SEQUENCE_LENGTH;
    localparam int CW = $clog2(N);
    localparam int SW = $clog2(SEQUENCE_LENGTH);
    localparam int PW = $clog2(STEP_CYCLES);

    typedef enum logic [1:0] {LOAD, FULL, STREAM} bank_st_e;

    bank_st_e st_q [NB];
    bank_st_e st_d [NB];

    logic                    wr_bank;
    logic                    rd_bank;
    logic                    nb;
    logic                    rb;
    logic [CW-1:0]           wr_cnt;
    logic [CW-1:0]           rd_base;
    logic [SW-1:0]           step;
    logic [PW-1:0]           pace;
    logic                    accept;
    logic                    wr_last;
    logic                    end_win;
    logic                    end_seq;
    logic                    start;
    logic signed [WIDTH-1:0] mem [NB][N];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int b = 0; b < NB; b++) st_q[b] <= LOAD;
        end else begin
            for (int b = 0; b < NB; b++) st_q[b] <= st_d[b];
        end
    end

    always_comb begin
        for (int b = 0; b < NB; b++) begin
            st_d[b] = st_q[b];
            if (flush) begin
                st_d[b] = LOAD;
            end else begin
                unique case (st_q[b])
                    LOAD:   if (accept && wr_last && wr_bank == 1'(b)) st_d[b] = FULL;
                    FULL:   if (start && nb == 1'(b)) st_d[b] = STREAM;
                    STREAM: if (end_seq && rd_bank == 1'(b)) st_d[b] = LOAD;
                    default: st_d[b] = LOAD;
                endcase
            end
        end
    end

    // When a stream ends, the other bank may take over on the same edge.
    always_comb begin
        s_ready = !reset && st_q[wr_bank] == LOAD;
        accept  = s_valid && s_ready && !flush;
        wr_last = wr_cnt == CW'(N - 1);
        end_win = x_valid && pace == PW'(STEP_CYCLES - 1);
        end_seq = end_win && step == SW'(SEQUENCE_LENGTH - 1);
        nb      = (PP && end_seq) ? ~rd_bank : rd_bank;
        start   = (!x_valid || end_seq) && st_q[nb] == FULL;
        rb      = start ? nb : rd_bank;
        rd_base = start ? '0 : CW'((int'(step) + 1) * x_SIZE);
    end

    always_ff @(posedge clk) begin
        if (accept) mem[wr_bank][wr_cnt] <= s_data;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            step     <= '0;
            pace     <= '0;
            x_valid  <= 1'b0;
            x_first  <= 1'b0;
            x_last   <= 1'b0;
            seq_done <= 1'b0;
            for (int f = 0; f < x_SIZE; f++) x_t[f] <= '0;
        end else if (flush) begin
            wr_bank  <= 1'b0;
            rd_bank  <= 1'b0;
            wr_cnt   <= '0;
            step     <= '0;
            pace     <= '0;
            x_valid  <= 1'b0;
            x_first  <= 1'b0;
            x_last   <= 1'b0;
            seq_done <= 1'b0;
            for (int f = 0; f < x_SIZE; f++) x_t[f] <= '0;
        end else begin
            seq_done <= end_seq;
            if (accept) begin
                wr_cnt <= wr_last ? '0 : wr_cnt + 1'b1;
                if (wr_last && PP) wr_bank <= ~wr_bank;
            end
            if (start) begin
                rd_bank <= nb;
                step    <= '0;
                pace    <= '0;
                x_valid <= 1'b1;
                x_first <= 1'b1;
                x_last  <= SEQUENCE_LENGTH == 1;
                for (int f = 0; f < x_SIZE; f++) x_t[f] <= mem[rb][rd_base + CW'(f)];
            end else if (end_seq) begin
                rd_bank <= PP ? ~rd_bank : rd_bank;
                step    <= '0;
                pace    <= '0;
                x_valid <= 1'b0;
                x_first <= 1'b0;
                x_last  <= 1'b0;
                for (int f = 0; f < x_SIZE; f++) x_t[f] <= '0;
            end else if (end_win) begin
                pace    <= '0;
                step    <= step + 1'b1;
                x_first <= 1'b0;
                x_last  <= (step + 1'b1) == SW'(SEQUENCE_LENGTH - 1);
                for (int f = 0; f < x_SIZE; f++) x_t[f] <= mem[rb][rd_base + CW'(f)];
            end else if (x_valid) begin
                pace <= pace + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gru_seq_feeder.sv
// Scoreboard bench for gru_seq_feeder: expected step windows are queued as
// beats are accepted and compared cycle by cycle while x_valid is high.
module tb_gru_seq_feeder;
    localparam int X = 6;
    localparam int L = 15;
    localparam int W = 16;
    localparam int S = 19;
    localparam int N = X * L;

    logic                clk = 1'b0;
    logic                reset;
    logic                flush;
    logic signed [W-1:0] s_data;
    logic                s_valid;
    logic                s_ready;
    logic signed [W-1:0] x_t [0:X-1];
    logic                x_valid;
    logic                x_first;
    logic                x_last;
    logic                seq_done;

    always #5 clk = ~clk;

    gru_seq_feeder #(
        .x_SIZE(X), .SEQUENCE_LENGTH(L), .WIDTH(W), .STEP_CYCLES(S)
    ) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .x_t(x_t), .x_valid(x_valid), .x_first(x_first),
        .x_last(x_last), .seq_done(seq_done)
    );

    typedef struct packed {
        logic         f;
        logic         l;
        logic [X*W-1:0] d;
    } win_t;

    win_t           exp_q [$];
    int             errs = 0;
    int             checks = 0;
    int             win = 0;
    bit             sd_exp = 1'b0;
    bit             prev_v = 1'b0;
    int             done_cnt = 0;
    int             vcnt = 0;
    int             fall_cnt = 0;
    int             beat_idx = 0;
    logic [X*W-1:0] acc = '0;

    task automatic chk(input string tag, input logic [127:0] got,
                       input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [X*W-1:0] pack_xt();
        logic [X*W-1:0] p;
        for (int f = 0; f < X; f++) p[f*W +: W] = x_t[f];
        return p;
    endfunction

    task automatic note_beat(input logic [W-1:0] d);
        win_t w;
        acc[(beat_idx % X)*W +: W] = d;
        if (beat_idx % X == X - 1) begin
            w.f = (beat_idx / X) == 0;
            w.l = (beat_idx / X) == L - 1;
            w.d = acc;
            exp_q.push_back(w);
        end
        beat_idx = (beat_idx + 1) % N;
    endtask

    task automatic clear_sb();
        exp_q.delete();
        win = 0;
        sd_exp = 1'b0;
        prev_v = 1'b0;
        beat_idx = 0;
    endtask

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            chk("seq_done", seq_done, sd_exp);
            sd_exp = 1'b0;
            if (seq_done) done_cnt++;
            if (prev_v && !x_valid) fall_cnt++;
            prev_v = x_valid;
            if (x_valid) begin
                vcnt++;
                if (exp_q.size() == 0) begin
                    chk("spurious x_valid", 1, 0);
                end else begin
                    chk("x_t window", {x_first, x_last, pack_xt()}, exp_q[0]);
                    win++;
                    if (win == S) begin
                        win = 0;
                        if (exp_q[0].l) sd_exp = 1'b1;
                        void'(exp_q.pop_front());
                    end
                end
            end else if (win != 0) begin
                chk("x_valid dropped mid window", 0, 1);
                win = 0;
            end
        end
    end

    task automatic send_beat(input logic [W-1:0] d, input bit gaps);
        int n;
        bit ok;
        if (gaps) begin
            n = $urandom_range(0, 3);
            if (n > 0) begin
                s_valid = 1'b0;
                repeat (n) @(posedge clk);
                #1;
            end
        end
        s_valid = 1'b1;
        s_data  = d;
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (s_ready) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
            end
        end
        s_valid = 1'b0;
        if (ok) note_beat(d);
        else chk("handshake timeout", 0, 1);
    endtask

    task automatic send_seq(input int base, input bit gaps);
        for (int k = 0; k < N; k++) send_beat(W'(base + k), gaps);
    endtask

    task automatic drain(input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && !x_valid && !sd_exp) ok = 1'b1;
        end
        chk("drain in time", ok, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, " x_valid"}, x_valid, 0);
        chk({tag, " flags"}, {x_first, x_last, seq_done}, 0);
        chk({tag, " x_t"}, pack_xt(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int d0, v0, f0;
        bit ok;
        reset   = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = 16'sd5;

        // 1: reset with stimulus active
        repeat (2) @(posedge clk);
        #1;
        chk_idle("reset");
        chk("reset s_ready", s_ready, 0);
        @(negedge clk);
        reset   = 1'b0;
        s_valid = 1'b0;
        #1;
        chk("s_ready after release", s_ready, 1);
        @(posedge clk);
        #1;

        // 2: back-to-back load, latency, window length
        d0 = done_cnt;
        v0 = vcnt;
        send_seq(0, 1'b0);
        @(negedge clk);
        #1;
        chk("FULL cycle x_valid", x_valid, 0);
        @(negedge clk);
        #1;
        chk("start x_valid/x_first", {x_valid, x_first}, 2'b11);
        chk("start x_t", pack_xt(), exp_q[0].d);
        drain(2000);
        chk("valid cycles", vcnt - v0, L * S);
        chk("seq_done count", done_cnt - d0, 1);

        // 3: random gaps, same data
        d0 = done_cnt;
        send_seq(0, 1'b1);
        drain(2000);
        chk("gaps seq_done count", done_cnt - d0, 1);

        // 4: second sequence during stream
        f0 = fall_cnt;
        send_seq(0, 1'b0);
`ifdef GRU_FEEDER_PINGPONG_EN
        send_seq(100, 1'b0);
        drain(3000);
        chk("pingpong x_valid falls", fall_cnt - f0, 1);
`else
        @(negedge clk);
        chk("stall s_ready", s_ready, 0);
        @(posedge clk);
        #1;
        d0 = done_cnt;
        send_beat(16'sd100, 1'b0);
        chk("91st beat after seq_done", done_cnt - d0, 1);
        for (int k = 1; k < N; k++) send_beat(W'(100 + k), 1'b0);
        drain(3000);
        chk("single-bank x_valid falls", fall_cnt - f0, 2);
`endif

        // 5: async reset inside window 7
        send_seq(0, 1'b0);
        ok = 1'b0;
        for (int i = 0; i < 2000 && !ok; i++) begin
            @(negedge clk);
            if (x_valid && x_t[0] == 16'sd42) ok = 1'b1;
        end
        chk("reach window 7", ok, 1);
        repeat (5) @(posedge clk);
        #3;
        reset = 1'b1;
        #1;
        chk_idle("async reset");
        chk("async reset s_ready", s_ready, 0);
        clear_sb();
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("s_ready after mid reset", s_ready, 1);
        @(posedge clk);
        #1;
        send_seq(200, 1'b1);
        drain(3000);

        // 6: flush on beat 40 handshake
        for (int k = 0; k < 40; k++) send_beat(W'(k), 1'b0);
        s_valid = 1'b1;
        s_data  = 16'sd40;
        flush   = 1'b1;
        @(negedge clk);
        chk("flush handshake ready", s_ready, 1);
        @(posedge clk);
        #1;
        flush   = 1'b0;
        s_valid = 1'b0;
        clear_sb();
        chk_idle("after flush");
        send_beat(16'sh7FFF, 1'b0);
        for (int k = 1; k < N; k++) send_beat(W'(k), 1'b0);
        drain(2000);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
